thumb_fetch_unit: RTL

//  Instruction fetch stage feeding the decoder in the Cortex-M0 Datapath.
//  - Fetches 32-bit words from instruction memory and splits them into 16-bit Thumb halfwords.
//  - Buffers halfwords in a small prefetch queue.
//  - Presents one complete instruction (16-bit, or 32-bit such as BL) per handshake, tagged with its PC.
//  - Redirects on branch/exception flush requested by the ControlUnit.

---
 rtl/m0_pkg.sv | 11 +
 rtl/fetch_hw_fifo.sv | 64 ++++++
 rtl/thumb_fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/m0_pkg.sv
// m0_pkg: shared types and constants for the Thumb fetch datapath
package m0_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;
  localparam int HW_W = 16;
  localparam logic [4:0] THUMB32_PFX_A = 5'b11101;
  localparam logic [4:0] THUMB32_PFX_B = 5'b11110;
  localparam logic [4:0] THUMB32_PFX_C = 5'b11111;
  function automatic logic is_thumb32(input logic [HW_W-1:0] hw);
    return hw[HW_W-1 -: 5] inside {THUMB32_PFX_A, THUMB32_PFX_B, THUMB32_PFX_C};
  endfunction
endpackage

// File: rtl/fetch_hw_fifo.sv
// fetch_hw_fifo: halfword prefetch queue with PC tags, 0/1/2 push and pop per cycle
module fetch_hw_fifo
  import m0_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [1:0]               push_n,
  input  logic [HW_W-1:0]          push_hw0,
  input  logic [HW_W-1:0]          push_hw1,
  input  logic [31:0]              push_tag0,
  input  logic [31:0]              push_tag1,
  input  logic [1:0]               pop_n,
  output logic [HW_W-1:0]          head_hw0,
  output logic [HW_W-1:0]          head_hw1,
  output logic [31:0]              head_tag,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [HW_W-1:0] hw_q [DEPTH];
  logic [HW_W-1:0] hw_d [DEPTH];
  logic [31:0] tag_q [DEPTH];
  logic [31:0] tag_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, wr1, rd1;
  logic [PW:0] cnt_q, cnt_d;
  assign wr1 = wr_q + 1'b1;
  assign rd1 = rd_q + 1'b1;
  assign head_hw0 = hw_q[rd_q];
  assign head_hw1 = hw_q[rd1];
  assign head_tag = tag_q[rd_q];
  assign count = cnt_q;
  always_comb begin
    hw_d = hw_q;
    tag_d = tag_q;
    if (push_n != 2'd0) begin
      hw_d[wr_q] = push_hw0;
      tag_d[wr_q] = push_tag0;
    end
    if (push_n == 2'd2) begin
      hw_d[wr1] = push_hw1;
      tag_d[wr1] = push_tag1;
    end
    wr_d = clr ? '0 : wr_q + PW'(push_n);
    rd_d = clr ? '0 : rd_q + PW'(pop_n);
    cnt_d = clr ? '0 : cnt_q + (PW+1)'(push_n) - (PW+1)'(pop_n);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_q <= '{default: '0};
      tag_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      hw_q <= hw_d;
      tag_q <= tag_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/thumb_fetch_unit.sv
// thumb_fetch_unit: fetches words, queues Thumb halfwords, presents 16/32-bit instructions
// Optional FETCH_PERF_EN adds request and decoder-stall counters.
module thumb_fetch_unit
  import m0_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        instr_is32,
  output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d, pc_hi;
  logic skip_lo_q, skip_lo_d, req_q, req_d, is32, take;
  logic [CW-1:0] count;
  logic [HW_W-1:0] hw0, hw1;
  logic [31:0] head_tag;
  logic [1:0] push_n, pop_n;
  assign pc_hi = fetch_pc_q + 32'd2;
  assign is32 = is_thumb32(hw0);
  assign instr_valid = is32 ? count >= CW'(2) : count != '0;
  assign instr_is32 = instr_valid & is32;
  assign instr = !instr_valid ? '0 : is32 ? {hw0, hw1} : {16'h0, hw0};
  assign instr_pc = instr_valid ? head_tag : '0;
  assign imem_req = req_q;
  assign imem_addr = addr_q;
  assign take = state_q == WAIT && imem_rvalid && !flush;
  assign push_n = !take ? 2'd0 : skip_lo_q ? 2'd1 : 2'd2;
  assign pop_n = (instr_valid && instr_ready && !flush) ? (is32 ? 2'd2 : 2'd1) : 2'd0;
  fetch_hw_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push_n   (push_n),
    .push_hw0 (skip_lo_q ? imem_rdata[31:16] : imem_rdata[15:0]),
    .push_hw1 (imem_rdata[31:16]),
    .push_tag0(skip_lo_q ? pc_hi : fetch_pc_q),
    .push_tag1(pc_hi),
    .pop_n    (pop_n),
    .head_hw0 (hw0),
    .head_hw1 (hw1),
    .head_tag (head_tag),
    .count    (count)
  );
  // Issue only with two free slots so a full word always fits when it returns.
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    skip_lo_d = skip_lo_q;
    req_d = 1'b0;
    addr_d = addr_q;
    if (flush) begin
      fetch_pc_d = flush_pc & ~32'h3;
      skip_lo_d = flush_pc[1];
      state_d = state_q == IDLE ? IDLE : DROP;
    end else if (state_q == IDLE) begin
      if (count <= CW'(DEPTH - 2)) begin
        req_d = 1'b1;
        addr_d = fetch_pc_q;
        state_d = WAIT;
      end
    end else if (imem_rvalid) begin
      state_d = IDLE;
      if (state_q == WAIT) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        skip_lo_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC & ~32'h3;
      skip_lo_q <= RESET_PC[1];
      req_q <= 1'b0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      skip_lo_q <= skip_lo_d;
      req_q <= req_d;
      addr_q <= addr_d;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, req_q};
    stall_cnt_d = stall_cnt_q + {31'd0, instr_ready && !instr_valid};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule
